// File: rtl/step_decoder.sv
// Receive-side monitor for the half-step phase bus: synchronises and glitch-filters the phase
// lines, tracks step direction against a reference index, and keeps a wrapping position count.
module step_decoder #(
    parameter int unsigned POS_W      = 11,
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned IDLE_CYC   = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phase,
    input  logic             zero,
    input  logic             clr_fault,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step_pulse,
    output logic             moving,
    output logic             locked,
    output logic             fault
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYC + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYC);

    typedef enum logic [1:0] {StUnlocked, StTracking, StFault} state_e;

    logic [3:0]       sync1_q, s_q, cand_q, acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic [2:0]       idx, delta;
    logic             code_valid, code_illegal;

    state_e            state_q, state_d;
    logic [2:0]        ref_q, ref_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d, pulse_q, pulse_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    // cnt saturates at CNT_MAX; re-accepting the same code is blocked by acc_q.
    assign accept = (s_q == cand_q) && (cnt_q == CNT_MAX) && (s_q != acc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            s_q     <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            sync1_q <= phase;
            s_q     <= sync1_q;
            if (s_q != cand_q) begin
                cand_q <= s_q;
                cnt_q  <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept) acc_q <= s_q;
        end
    end

    always_comb begin
        idx          = '0;
        code_valid   = 1'b1;
        code_illegal = 1'b0;
        case (s_q)
            4'b0001: idx = 3'd0;
            4'b0011: idx = 3'd1;
            4'b0010: idx = 3'd2;
            4'b0110: idx = 3'd3;
            4'b0100: idx = 3'd4;
            4'b1100: idx = 3'd5;
            4'b1000: idx = 3'd6;
            4'b1001: idx = 3'd7;
            4'b0000: code_valid = 1'b0;
            default: begin
                code_valid   = 1'b0;
                code_illegal = 1'b1;
            end
        endcase
    end

    assign delta = idx - ref_q;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        idle_d  = (idle_q != '0) ? idle_q - IDLE_W'(1) : '0;
        unique case (state_q)
            StUnlocked: begin
                if (accept && code_valid) begin
                    ref_d   = idx;
                    state_d = StTracking;
                end else if (accept && code_illegal) begin
                    state_d = StFault;
                end
            end
            StTracking: begin
                if (accept && code_illegal) begin
                    state_d = StFault;
                end else if (accept && code_valid) begin
                    if (delta == 3'd1) begin
                        pos_d   = pos_q + POS_W'(1);
                        dir_d   = 1'b0;
                        pulse_d = 1'b1;
                        ref_d   = idx;
                    end else if (delta == 3'd7) begin
                        pos_d   = pos_q - POS_W'(1);
                        dir_d   = 1'b1;
                        pulse_d = 1'b1;
                        ref_d   = idx;
                    end else if (delta != 3'd0) begin
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                // A fresh illegal code in the clearing cycle keeps the fault.
                if (clr_fault && !(accept && code_illegal)) state_d = StUnlocked;
            end
            default: state_d = StUnlocked;
        endcase
        if (pulse_d) idle_d = IDLE_LOAD;
        if (state_d == StFault && state_q != StFault) idle_d = '0;
        if (zero) pos_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StUnlocked;
            ref_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            idle_q  <= idle_d;
        end
    end

    assign position   = pos_q;
    assign dir        = dir_q;
    assign step_pulse = pulse_q;
    assign moving     = (idle_q != '0);
    assign locked     = (state_q == StTracking);
    assign fault      = (state_q == StFault);

endmodule
